// File: rtl/ps2_key_matrix.sv
// rtl/ps2_key_matrix.sv - PS/2 event to emulated keyboard matrix with lock keys and hold pool
module ps2_key_matrix #(
    parameter int ROWS        = 8,
    parameter int COLS        = 8,
    parameter int ROW_W       = 3,
    parameter int COL_W       = 3,
    parameter int SLOTS       = 4,
    parameter int HOLD_CYCLES = 858000,
    parameter int TIMER_W     = 20
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic [10:0]              ps2_key,
    input  logic                     map_we,
    input  logic [8:0]               map_addr,
    input  logic [2+ROW_W+COL_W-1:0] map_data,
    input  logic [ROWS*COLS-1:0]     ext_keys,
    input  logic [ROWS-1:0]          row_sel_n,
    output logic [COLS-1:0]          col_n,
    output logic [ROWS*COLS-1:0]     lock_state,
    output logic                     busy
);
    localparam int MW = 2 + ROW_W + COL_W;
    localparam int NK = ROWS * COLS;
    localparam int KW = (NK > 1) ? $clog2(NK) : 1;
    localparam logic [TIMER_W-1:0] HOLD = TIMER_W'(HOLD_CYCLES);

    logic              r_tog;
    logic              r_s1_vld, r_s1_pr, r_s2_vld, r_s2_pr;
    logic [8:0]        r_s1_code;
    logic [MW-1:0]     r_map;
    logic [MW-1:0]     r_ram [512];
    logic [NK-1:0]     r_state, w_state_n, r_lock, w_lock_n, w_eff;
    logic [SLOTS-1:0]  r_occ, w_occ_n;
    logic [KW-1:0]     r_key [SLOTS];
    logic [KW-1:0]     w_key_n [SLOTS];
    logic [TIMER_W-1:0] r_tmr [SLOTS];
    logic [TIMER_W-1:0] w_tmr_n [SLOTS];
    logic [COLS-1:0]   r_col_n, w_col_n;
    logic              r_busy;
    logic [ROW_W-1:0]  w_row;
    logic [COL_W-1:0]  w_col;
    logic [KW-1:0]     w_k;
    logic              w_apply, w_found, w_acc;

    assign w_row   = r_map[COL_W +: ROW_W];
    assign w_col   = r_map[COL_W-1:0];
    assign w_k     = KW'(32'(w_row) * COLS + 32'(w_col));
    assign w_apply = r_s2_vld && r_map[MW-1] && (32'(w_row) < ROWS) && (32'(w_col) < COLS);

    // Read-before-write: a same-cycle write to the looked-up address returns the old entry
    always_ff @(posedge clk_sys) begin
        r_map <= r_ram[r_s1_code];
        if (map_we) begin
            r_ram[map_addr] <= map_data;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_lock_n  = r_lock;
        w_occ_n   = r_occ;
        w_key_n   = r_key;
        w_tmr_n   = r_tmr;
        w_found   = 1'b0;
        for (int s = 0; s < SLOTS; s++) begin
            if (r_occ[s]) begin
                if (r_tmr[s] <= TIMER_W'(1)) begin
                    w_occ_n[s]            = 1'b0;
                    w_state_n[r_key[s]]   = 1'b0;
                end else begin
                    w_tmr_n[s] = r_tmr[s] - 1'b1;
                end
            end
        end
        // Applied after expiry so a press beats a same-cycle expiry and freed slots are reusable
        if (w_apply) begin
            if (r_map[MW-2]) begin
                if (r_s2_pr) begin
                    w_lock_n[w_k] = ~r_lock[w_k];
                end
            end else if (r_s2_pr) begin
                w_state_n[w_k] = 1'b1;
                for (int s = 0; s < SLOTS; s++) begin
                    if (r_occ[s] && (r_key[s] == w_k)) begin
                        w_occ_n[s] = 1'b0;
                    end
                end
            end else begin
                for (int s = 0; s < SLOTS; s++) begin
                    if (!w_found && !w_occ_n[s]) begin
                        w_found    = 1'b1;
                        w_occ_n[s] = 1'b1;
                        w_key_n[s] = w_k;
                        w_tmr_n[s] = HOLD;
                    end
                end
                if (!w_found) begin
                    w_state_n[w_k] = 1'b0;
                end
            end
        end
    end

    assign w_eff = r_state | r_lock | ext_keys;

    always_comb begin
        w_col_n = '1;
        w_acc   = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            w_acc = 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                w_acc = w_acc | (w_eff[r*COLS+c] & ~row_sel_n[r]);
            end
            w_col_n[c] = ~w_acc;
        end
    end

    always_ff @(posedge clk_sys) begin
        r_s1_pr   <= ps2_key[9];
        r_s1_code <= ps2_key[8:0];
        r_s2_pr   <= r_s1_pr;
        r_key     <= w_key_n;
        r_tmr     <= w_tmr_n;
        if (reset) begin
            r_tog    <= ps2_key[10];
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
            r_state  <= '0;
            r_lock   <= '0;
            r_occ    <= '0;
            r_col_n  <= '1;
            r_busy   <= 1'b0;
        end else begin
            r_tog    <= ps2_key[10];
            r_s1_vld <= ps2_key[10] ^ r_tog;
            r_s2_vld <= r_s1_vld;
            r_state  <= w_state_n;
            r_lock   <= w_lock_n;
            r_occ    <= w_occ_n;
            r_col_n  <= w_col_n;
            r_busy   <= |w_occ_n;
        end
    end

    assign col_n      = r_col_n;
    assign lock_state = r_lock;
    assign busy       = r_busy;
endmodule
